// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter: FSM state encoding and the
// nominal system clock rate used when sizing gate windows and dividers.
package freq_meter_pkg;

  localparam int CLK_HZ = 10_000_000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/freq_meter_edge_sync.sv
// Two-flop synchronizer for an asynchronous input plus a history flop,
// producing a one-cycle pulse for every synchronized rising edge.
module edge_sync (
  input  logic clk_in,
  input  logic rst,
  input  logic sig_in,
  output logic sig_edge
);

  logic s0_reg;
  logic s1_reg;
  logic prev_reg;

  // Synchronizer chain; runs in every FSM state so it is always settled.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      s0_reg   <= 1'b0;
      s1_reg   <= 1'b0;
      prev_reg <= 1'b0;
    end else begin
      s0_reg   <= sig_in;
      s1_reg   <= s0_reg;
      prev_reg <= s1_reg;
    end
  end

  assign sig_edge = s1_reg & ~prev_reg;

endmodule

// File: rtl/freq_meter.sv
// Gated edge counter: counts synchronized rising edges of sig_in over a
// window of GATE_CYCLES clocks and publishes a saturating result.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = 10_000_000,
  parameter int CNT_W       = 24,
  parameter bit CONTINUOUS  = 1'b0
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  output logic [CNT_W-1:0] freq_count,
  output logic             valid,
  output logic             busy,
  output logic             overflow
);

  localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_t            state_reg;
  state_t            state_next;
  logic [GATE_W-1:0] gate_cnt_reg;
  logic [CNT_W-1:0]  edge_cnt_reg;
  logic              ovf_int_reg;
  logic [CNT_W-1:0]  res_reg;
  logic              ovf_res_reg;

  logic              sig_edge;
  logic              gate_last;
  logic              edge_at_max;
  logic [CNT_W-1:0]  edge_sum;
  logic              ovf_sum;

  edge_sync u_edge_sync (
    .clk_in   (clk_in),
    .rst      (rst),
    .sig_in   (sig_in),
    .sig_edge (sig_edge)
  );

  // Final gate cycle; its edge still belongs to this gate.
  assign gate_last   = (state_reg == ST_COUNT) && (gate_cnt_reg == GATE_LAST);
  assign edge_at_max = (edge_cnt_reg == CNT_MAX);
  assign edge_sum    = (sig_edge && !edge_at_max) ? edge_cnt_reg + 1'b1 : edge_cnt_reg;
  assign ovf_sum     = ovf_int_reg | (sig_edge & edge_at_max);

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state and status outputs; start is only honoured from IDLE.
  always_comb begin
    state_next = state_reg;
    valid      = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_COUNT;
      end
      ST_COUNT: begin
        busy = 1'b1;
        if (gate_last) state_next = ST_DONE;
      end
      ST_DONE: begin
        busy       = 1'b1;
        valid      = 1'b1;
        state_next = CONTINUOUS ? ST_COUNT : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Gate and edge counters; cleared whenever not counting so every gate starts fresh.
  // The gate counter returns to zero on its last cycle rather than running past the window.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      gate_cnt_reg <= '0;
      edge_cnt_reg <= '0;
      ovf_int_reg  <= 1'b0;
      res_reg      <= '0;
      ovf_res_reg  <= 1'b0;
    end else if (state_reg == ST_COUNT) begin
      gate_cnt_reg <= gate_last ? '0 : gate_cnt_reg + 1'b1;
      edge_cnt_reg <= edge_sum;
      ovf_int_reg  <= ovf_sum;
      if (gate_last) begin
        res_reg     <= edge_sum;
        ovf_res_reg <= ovf_sum;
      end
    end else begin
      gate_cnt_reg <= '0;
      edge_cnt_reg <= '0;
      ovf_int_reg  <= 1'b0;
    end
  end

  // Published result, updated once per completed gate.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      freq_count <= '0;
      overflow   <= 1'b0;
    end else if (state_reg == ST_DONE) begin
      freq_count <= res_reg;
      overflow   <= ovf_res_reg;
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: three instances (24-bit single-shot,
// 4-bit single-shot, 24-bit continuous) share clock, reset and sig_in.
module tb_freq_meter;

  logic        clk;
  logic        rst;
  logic        sig_in;
  logic        start_a, start_b, start_c;
  logic [23:0] fc_a, fc_c;
  logic [3:0]  fc_b;
  logic        valid_a, valid_b, valid_c;
  logic        busy_a, busy_b, busy_c;
  logic        ovf_a, ovf_b, ovf_c;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int sig_per  = 0;
  int sig_t0   = 32'h7fffffff;
  int sel      = 0;

  logic [31:0] cnt_sel;
  logic        valid_sel, busy_sel, ovf_sel;

  freq_meter #(.GATE_CYCLES(100), .CNT_W(24), .CONTINUOUS(1'b0)) dut_a (
    .clk_in(clk), .rst(rst), .sig_in(sig_in), .start(start_a),
    .freq_count(fc_a), .valid(valid_a), .busy(busy_a), .overflow(ovf_a));

  freq_meter #(.GATE_CYCLES(100), .CNT_W(4), .CONTINUOUS(1'b0)) dut_b (
    .clk_in(clk), .rst(rst), .sig_in(sig_in), .start(start_b),
    .freq_count(fc_b), .valid(valid_b), .busy(busy_b), .overflow(ovf_b));

  freq_meter #(.GATE_CYCLES(100), .CNT_W(24), .CONTINUOUS(1'b1)) dut_c (
    .clk_in(clk), .rst(rst), .sig_in(sig_in), .start(start_c),
    .freq_count(fc_c), .valid(valid_c), .busy(busy_c), .overflow(ovf_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Route the instance under test to common observation signals.
  always_comb begin
    cnt_sel   = {8'd0, fc_a};
    valid_sel = valid_a;
    busy_sel  = busy_a;
    ovf_sel   = ovf_a;
    if (sel == 1) begin
      cnt_sel   = {28'd0, fc_b};
      valid_sel = valid_b;
      busy_sel  = busy_b;
      ovf_sel   = ovf_b;
    end else if (sel == 2) begin
      cnt_sel   = {8'd0, fc_c};
      valid_sel = valid_c;
      busy_sel  = busy_c;
      ovf_sel   = ovf_c;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one clock, then drive sig_in for the new cycle from the generator settings.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (sig_per == 0)       sig_in = (cyc >= sig_t0);
    else if (cyc < sig_t0)  sig_in = 1'b0;
    else                    sig_in = (((cyc - sig_t0) % sig_per) < (sig_per / 2));
  endtask

  task automatic quiet(input int n);
    sig_per = 0;
    sig_t0  = 32'h7fffffff;
    sig_in  = 1'b0;
    repeat (n) tick();
  endtask

  // Caller raises the start line(s) in cycle 0; checks busy/valid each cycle and the result after valid.
  task automatic run_gate(input string tag, input logic [31:0] exp_cnt, input logic exp_ovf);
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
    for (int r = 1; r <= 102; r++) begin
      check({tag, "_busy"}, 32'(busy_sel), 32'(r <= 101));
      check({tag, "_valid"}, 32'(valid_sel), 32'(r == 101));
      if (r == 102) begin
        check({tag, "_count"}, cnt_sel, exp_cnt);
        check({tag, "_ovf"}, 32'(ovf_sel), 32'(exp_ovf));
        $display("gate %s: freq_count=%0d overflow=%0d", tag, cnt_sel, ovf_sel);
      end else begin
        tick();
      end
    end
  endtask

  initial begin
    int pulses;
    rst = 1'b1; sig_in = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check("rst_cnt_a", {8'd0, fc_a}, 32'd0);
    check("rst_valid_a", 32'(valid_a), 32'd0);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_ovf_a", 32'(ovf_a), 32'd0);
    check("rst_busy_b", 32'(busy_b), 32'd0);
    check("rst_busy_c", 32'(busy_c), 32'd0);

    // 1: period 10, first rise 3 cycles after start
    sel = 0; quiet(5);
    sig_per = 10; sig_t0 = cyc + 3; start_a = 1'b1;
    run_gate("t1", 32'd10, 1'b0);

    // 2: level high through the whole gate
    quiet(2);
    sig_per = 0; sig_t0 = 0;
    repeat (5) tick();
    start_a = 1'b1;
    run_gate("t2", 32'd0, 1'b0);

    // 3: 25 edges saturate the 4-bit counter; the 24-bit one sees all 25
    sel = 1; quiet(5);
    sig_per = 4; sig_t0 = cyc + 1; start_a = 1'b1; start_b = 1'b1;
    run_gate("t3ovf", 32'd15, 1'b1);
    check("t3_wide_cnt", {8'd0, fc_a}, 32'd25);
    check("t3_wide_ovf", 32'(ovf_a), 32'd0);
    quiet(5);
    sig_per = 10; sig_t0 = cyc + 3; start_b = 1'b1;
    run_gate("t3rec", 32'd10, 1'b0);

    // 4: reset in the middle of a gate
    sel = 0; quiet(5);
    sig_per = 10; sig_t0 = cyc + 3; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (49) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_busy", 32'(busy_a), 32'd0);
    check("t4_cnt", {8'd0, fc_a}, 32'd0);
    check("t4_valid", 32'(valid_a), 32'd0);
    pulses = 0;
    repeat (110) begin
      tick();
      if (valid_a) pulses++;
    end
    check("t4_no_valid", 32'(pulses), 32'd0);
    $display("reset mid-gate: valid pulses afterwards=%0d", pulses);
    quiet(5);
    sig_per = 10; sig_t0 = cyc + 3; start_a = 1'b1;
    run_gate("t4new", 32'd10, 1'b0);

    // 6: lone rise landing in the last COUNT cycle, then in the DONE cycle
    quiet(5);
    sig_per = 0; sig_t0 = cyc + 98; start_a = 1'b1;
    run_gate("t6last", 32'd1, 1'b0);
    quiet(5);
    sig_per = 0; sig_t0 = cyc + 99; start_a = 1'b1;
    run_gate("t6done", 32'd0, 1'b0);

    // 5: continuous mode, extra starts during COUNT must not disturb timing
    sel = 2; quiet(5);
    sig_per = 10; sig_t0 = cyc + 3; start_c = 1'b1;
    tick();
    start_c = 1'b0;
    for (int r = 1; r <= 305; r++) begin
      check("t5_busy", 32'(busy_sel), 32'd1);
      check("t5_valid", 32'(valid_sel), 32'(r == 101 || r == 202 || r == 303));
      if (r == 102 || r == 203 || r == 304) begin
        check("t5_count", cnt_sel, 32'd10);
        $display("continuous gate ending r=%0d: freq_count=%0d", r - 1, cnt_sel);
      end
      start_c = (r == 30 || r == 150 || r == 250);
      tick();
    end
    start_c = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
